// File: rtl/plic_pkg.sv
// Shared types and register offsets for the PLIC context-0 claim/complete initiator.
package plic_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLAIM,
      RDWAIT,
      HANDOFF,
      SERVICE,
      COMPLETE,
      HOLDOFF
   } plic_state_e;

   localparam logic [25:0] CLAIM_OFFSET  = 26'h20_0004;
   localparam logic [25:0] ENABLE_OFFSET = 26'h00_2000;

endpackage

// File: rtl/plic_claim_complete_initiator.sv
// Hart-side PLIC context-0 claim/complete initiator: claim read, core handoff, complete write.
// Optional feature: `PLIC_SPURIOUS_CNT_EN adds a saturating spurious-claim counter output.
module plic_claim_complete_initiator
   import plic_pkg::*;
#(
   parameter int unsigned        ADDR_W     = 26,
   parameter int unsigned        DATA_W     = 32,
   parameter int unsigned        ID_W       = 10,
   parameter logic [ADDR_W-1:0]  CLAIM_ADDR = ADDR_W'(CLAIM_OFFSET),
   parameter int unsigned        RD_LAT     = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              context__0__eip,
   output logic              cs,
   output logic              we,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wr_data,
   input  logic [DATA_W-1:0] rd_data,
   output logic              irq_valid,
   output logic [ID_W-1:0]   irq_id,
   input  logic              irq_ready,
   input  logic              irq_done,
`ifdef PLIC_SPURIOUS_CNT_EN
   output logic [15:0]       spurious_cnt,
`endif
   output logic              busy
);

   localparam int unsigned CNT_W = $clog2(RD_LAT + 1);

   plic_state_e       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic              cs_q, cs_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              irq_valid_q, irq_valid_d;
   logic              busy_q, busy_d;
   logic              rd_sample_c;
   logic              unused_rd_hi;

   // Upper claim-data bits carry no source ID.
   assign unused_rd_hi = ^rd_data[DATA_W-1:ID_W];
   assign rd_sample_c  = (state_q == RDWAIT) && (cnt_q == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         id_q        <= '0;
         cs_q        <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wr_data_q   <= '0;
         irq_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         id_q        <= id_d;
         cs_q        <= cs_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wr_data_q   <= wr_data_d;
         irq_valid_q <= irq_valid_d;
         busy_q      <= busy_d;
      end
   end

   // Next state; outputs are decoded from the next state so they register in step with it.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      id_d        = id_q;
      cs_d        = 1'b0;
      we_d        = 1'b0;
      addr_d      = '0;
      wr_data_d   = '0;
      irq_valid_d = 1'b0;
      busy_d      = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (en && context__0__eip) state_d = CLAIM;
         end
         CLAIM: begin
            state_d = RDWAIT;
            cnt_d   = CNT_W'(RD_LAT - 1);
         end
         RDWAIT: begin
            if (cnt_q == '0) begin
               id_d    = rd_data[ID_W-1:0];
               state_d = (id_d == '0) ? HOLDOFF : HANDOFF;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         HANDOFF: begin
            if (irq_ready) state_d = irq_done ? COMPLETE : SERVICE;
         end
         SERVICE: begin
            if (irq_done) state_d = COMPLETE;
         end
         COMPLETE: begin
            state_d = HOLDOFF;
         end
         // eip already reflects the complete here, so the IDLE decision is taken on exit.
         HOLDOFF: begin
            state_d = (en && context__0__eip) ? CLAIM : IDLE;
         end
         default: state_d = IDLE;
      endcase

      cs_d        = (state_d == CLAIM) || (state_d == COMPLETE);
      we_d        = (state_d == COMPLETE);
      addr_d      = cs_d ? CLAIM_ADDR : '0;
      wr_data_d   = (state_d == COMPLETE) ? {(DATA_W-ID_W)'(0), id_q} : '0;
      irq_valid_d = (state_d == HANDOFF);
      busy_d      = (state_d != IDLE);
   end

`ifdef PLIC_SPURIOUS_CNT_EN
   logic [15:0] spur_q, spur_d;

   // Count ID-0 claims, saturating at all-ones.
   always_comb begin
      spur_d = spur_q;
      if (rd_sample_c && (rd_data[ID_W-1:0] == '0) && (spur_q != 16'hFFFF))
         spur_d = spur_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) spur_q <= '0;
      else      spur_q <= spur_d;
   end

   assign spurious_cnt = spur_q;
`else
   logic unused_rd_sample;
   assign unused_rd_sample = rd_sample_c;
`endif

   assign cs        = cs_q;
   assign we        = we_q;
   assign addr      = addr_q;
   assign wr_data   = wr_data_q;
   assign irq_valid = irq_valid_q;
   assign irq_id    = id_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_plic_claim_complete_initiator.sv
// Directed bench for plic_claim_complete_initiator (RD_LAT=1); expectations are hand-derived cycle by cycle.
module tb_plic_claim_complete_initiator;

   logic        clk;
   logic        rst;
   logic        en;
   logic        eip;
   logic        cs;
   logic        we;
   logic [25:0] addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic        irq_valid;
   logic [9:0]  irq_id;
   logic        irq_ready;
   logic        irq_done;
   logic        busy;
`ifdef PLIC_SPURIOUS_CNT_EN
   logic [15:0] spurious_cnt;
`endif

   int checks;
   int failures;

   plic_claim_complete_initiator dut (
      .clk             (clk),
      .rst             (rst),
      .en              (en),
      .context__0__eip (eip),
      .cs              (cs),
      .we              (we),
      .addr            (addr),
      .wr_data         (wr_data),
      .rd_data         (rd_data),
      .irq_valid       (irq_valid),
      .irq_id          (irq_id),
      .irq_ready       (irq_ready),
      .irq_done        (irq_done),
`ifdef PLIC_SPURIOUS_CNT_EN
      .spurious_cnt    (spurious_cnt),
`endif
      .busy            (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_bus(input string tag, input logic c, input logic w,
                          input logic [31:0] a, input logic [31:0] d);
      chk({tag, ".cs"}, 32'(cs), 32'(c));
      chk({tag, ".we"}, 32'(we), 32'(w));
      chk({tag, ".addr"}, 32'(addr), a);
      chk({tag, ".wr_data"}, wr_data, d);
   endtask

   localparam logic [31:0] CA = 32'h0020_0004;

   initial begin
      int cs_hits;
      checks = 0; failures = 0;
      rst = 1'b0; en = 1'b1; eip = 1'b1; rd_data = 32'h0;
      irq_ready = 1'b0; irq_done = 1'b0;

      // 1: reset holds everything at zero even with eip pending
      #3;
      chk_bus("rst", 1'b0, 1'b0, 32'h0, 32'h0);
      chk("rst.irq_valid", 32'(irq_valid), 32'h0);
      chk("rst.irq_id", 32'(irq_id), 32'h0);
      chk("rst.busy", 32'(busy), 32'h0);
      tick(); tick();
      chk("rst_hold.cs", 32'(cs), 32'h0);
      chk("rst_hold.busy", 32'(busy), 32'h0);

      // 2: claim ID 1, three-cycle ready stall, separate done
      rd_data = 32'h1;
      rst = 1'b1;
      tick();
      chk_bus("t2.claim", 1'b1, 1'b0, CA, 32'h0);
      chk("t2.claim.busy", 32'(busy), 32'h1);
      eip = 1'b0;
      tick();
      chk("t2.rdwait.cs", 32'(cs), 32'h0);
      chk("t2.rdwait.valid", 32'(irq_valid), 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("t2.hold%0d.valid", i), 32'(irq_valid), 32'h1);
         chk($sformatf("t2.hold%0d.id", i), 32'(irq_id), 32'h1);
      end
      irq_ready = 1'b1;
      tick();
      irq_ready = 1'b0;
      chk("t2.service.valid", 32'(irq_valid), 32'h0);
      chk("t2.service.busy", 32'(busy), 32'h1);
      tick();
      chk("t2.service2.cs", 32'(cs), 32'h0);
      irq_done = 1'b1;
      tick();
      irq_done = 1'b0;
      chk_bus("t2.complete", 1'b1, 1'b1, CA, 32'h1);
      tick();
      chk_bus("t2.holdoff", 1'b0, 1'b0, 32'h0, 32'h0);
      chk("t2.holdoff.busy", 32'(busy), 32'h1);
      tick();
      chk("t2.idle.busy", 32'(busy), 32'h0);

      // 3: spurious claim (ID 0)
      rd_data = 32'h0;
      eip = 1'b1;
      tick();
      chk_bus("t3.claim", 1'b1, 1'b0, CA, 32'h0);
      eip = 1'b0;
      tick();
      tick();
      chk("t3.holdoff.valid", 32'(irq_valid), 32'h0);
      chk("t3.holdoff.cs", 32'(cs), 32'h0);
      chk("t3.holdoff.busy", 32'(busy), 32'h1);
`ifdef PLIC_SPURIOUS_CNT_EN
      chk("t3.spurious_cnt", 32'(spurious_cnt), 32'h1);
`endif
      tick();
      chk("t3.idle.busy", 32'(busy), 32'h0);
      chk("t3.idle.cs", 32'(cs), 32'h0);

      // 4: ready and done in the same cycle; upper data bits ignored
      rd_data = 32'hABCD_FC02;
      eip = 1'b1;
      tick();
      chk("t4.claim.cs", 32'(cs), 32'h1);
      eip = 1'b0;
      tick();
      tick();
      chk("t4.valid", 32'(irq_valid), 32'h1);
      chk("t4.id", 32'(irq_id), 32'h2);
      irq_ready = 1'b1; irq_done = 1'b1;
      tick();
      irq_ready = 1'b0; irq_done = 1'b0;
      chk_bus("t4.complete", 1'b1, 1'b1, CA, 32'h2);
      chk("t4.complete.valid", 32'(irq_valid), 32'h0);
      tick();
      tick();
      chk("t4.idle.busy", 32'(busy), 32'h0);

      // 5: eip held across the complete -> back-to-back claim
      rd_data = 32'h5;
      eip = 1'b1;
      tick();
      chk("t5.claim1.cs", 32'(cs), 32'h1);
      tick();
      tick();
      chk("t5.id1", 32'(irq_id), 32'h5);
      irq_ready = 1'b1; irq_done = 1'b1;
      tick();
      irq_ready = 1'b0; irq_done = 1'b0;
      chk_bus("t5.complete1", 1'b1, 1'b1, CA, 32'h5);
      rd_data = 32'h7;
      tick();
      chk("t5.holdoff.cs", 32'(cs), 32'h0);
      tick();
      chk_bus("t5.claim2", 1'b1, 1'b0, CA, 32'h0);
      eip = 1'b0;
      tick();
      tick();
      chk("t5.valid2", 32'(irq_valid), 32'h1);
      chk("t5.id2", 32'(irq_id), 32'h7);
      irq_ready = 1'b1;
      tick();
      irq_ready = 1'b0;
      irq_done = 1'b1;
      tick();
      irq_done = 1'b0;
      chk_bus("t5.complete2", 1'b1, 1'b1, CA, 32'h7);
      tick();
      tick();
      chk("t5.idle.busy", 32'(busy), 32'h0);

      // 6: reset mid-service abandons the transaction
      rd_data = 32'h3;
      eip = 1'b1;
      tick();
      eip = 1'b0;
      tick();
      tick();
      chk("t6.id", 32'(irq_id), 32'h3);
      irq_ready = 1'b1;
      tick();
      irq_ready = 1'b0;
      tick();
      chk("t6.service.busy", 32'(busy), 32'h1);
      rst = 1'b0;
      #1;
      chk_bus("t6.rst", 1'b0, 1'b0, 32'h0, 32'h0);
      chk("t6.rst.valid", 32'(irq_valid), 32'h0);
      chk("t6.rst.id", 32'(irq_id), 32'h0);
      chk("t6.rst.busy", 32'(busy), 32'h0);
`ifdef PLIC_SPURIOUS_CNT_EN
      chk("t6.rst.spurious_cnt", 32'(spurious_cnt), 32'h0);
`endif
      irq_done = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      irq_done = 1'b0;
      cs_hits = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (cs) cs_hits++;
      end
      chk("t6.no_complete", 32'(cs_hits), 32'h0);
      chk("t6.after.busy", 32'(busy), 32'h0);

      // en=0 blocks new claims even with eip pending
      en = 1'b0;
      eip = 1'b1;
      cs_hits = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (cs || busy) cs_hits++;
      end
      chk("t6.en0.no_cs", 32'(cs_hits), 32'h0);
      en = 1'b1;
      tick();
      chk_bus("t6.en1.claim", 1'b1, 1'b0, CA, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
